// File: rtl/r16_stage_sequencer_if.sv
// rtl/r16_stage_sequencer_if.sv - control, twiddle-request and sideband signals of the R16 stage sequencer
interface r16_stage_sequencer_if #(
    parameter int GRP_W = 4,
    parameter int STG_W = 2
);
    logic             start;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             tf_req;
    logic [STG_W-1:0] tf_stage;
    logic [GRP_W-1:0] tf_group;
    logic             out_valid;
    logic [STG_W-1:0] out_stage;
    logic [GRP_W-1:0] out_group;
    logic             busy;
    logic             done;

    modport slave (
        input  start, flush, in_valid,
        output in_ready, tf_req, tf_stage, tf_group,
        output out_valid, out_stage, out_group, busy, done
    );

    modport master (
        output start, flush, in_valid,
        input  in_ready, tf_req, tf_stage, tf_group,
        input  out_valid, out_stage, out_group, busy, done
    );
endinterface

// File: rtl/r16_stage_sequencer.sv
// rtl/r16_stage_sequencer.sv - sequences group/stage indices of one radix-16 transform and re-times a sideband
module r16_stage_sequencer #(
    parameter int DELAY  = 2,
    parameter int GROUPS = 16,
    parameter int STAGES = 3,
    parameter int GRP_W  = 4,
    parameter int STG_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    r16_stage_sequencer_if.slave   sq
);
    localparam int EW  = 1 + STG_W + GRP_W;
    localparam int DCW = $clog2(DELAY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [EW-1:0]    pipe_q [DELAY];
    logic             run;
    logic             accept;

    assign run         = (state_q == S_RUN);
    assign accept      = sq.in_valid & run;
    assign sq.in_ready = run;
    assign sq.tf_req   = accept;
    assign sq.tf_stage = stg_q;
    assign sq.tf_group = grp_q;
    assign sq.busy     = run | (state_q == S_DRAIN);
    assign sq.done     = (state_q == S_DONE);
    assign {sq.out_valid, sq.out_stage, sq.out_group} = pipe_q[DELAY-1];

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        stg_d   = stg_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (sq.start) begin
                    state_d = S_RUN;
                    grp_d   = '0;
                    stg_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (grp_q == GRP_W'(GROUPS - 1)) begin
                        grp_d = '0;
                        // Stage also wraps on the final accept so counters stay in range while draining.
                        if (stg_q == STG_W'(STAGES - 1)) begin
                            stg_d   = '0;
                            state_d = S_DRAIN;
                            dcnt_d  = '0;
                        end else begin
                            stg_d = stg_q + 1'b1;
                        end
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCW'(DELAY - 1)) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (sq.flush) begin
            state_d = S_IDLE;
            grp_d   = '0;
            stg_d   = '0;
            dcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            stg_q   <= '0;
            dcnt_q  <= '0;
            for (int i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            stg_q   <= stg_d;
            dcnt_q  <= dcnt_d;
            if (sq.flush) begin
                for (int i = 0; i < DELAY; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                // Sideband shifts every cycle so it tracks the fixed-latency data delay line.
                pipe_q[0] <= {accept, stg_q, grp_q};
                for (int i = 1; i < DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_r16_stage_sequencer.sv
// tb/tb_r16_stage_sequencer.sv - scoreboard bench for r16_stage_sequencer
module tb_r16_stage_sequencer;
    typedef struct {
        int         due;
        logic [1:0] stg;
        logic [3:0] grp;
    } ent_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    ent_t q0[$];
    ent_t q1[$];

    r16_stage_sequencer_if #(.GRP_W(4), .STG_W(2)) s0 ();
    r16_stage_sequencer_if #(.GRP_W(1), .STG_W(1)) s1 ();

    r16_stage_sequencer #(.DELAY(2), .GROUPS(16), .STAGES(3), .GRP_W(4), .STG_W(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (s0.slave)
    );

    r16_stage_sequencer #(.DELAY(1), .GROUPS(2), .STAGES(1), .GRP_W(1), .STG_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (s1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sideband scoreboard for the default-parameter instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s0.out_valid) begin
                n_chk++;
                if (q0.size() == 0) begin
                    $display("FAIL out_unexpected cyc=%0d got stage=%0d group=%0d expected no out_valid", cyc, s0.out_stage, s0.out_group);
                end else begin
                    ent_t e;
                    e = q0.pop_front();
                    if (e.due !== cyc || e.stg !== s0.out_stage || e.grp !== s0.out_group)
                        $display("FAIL out_sideband cyc=%0d got stage=%0d group=%0d expected cyc=%0d stage=%0d group=%0d",
                                 cyc, s0.out_stage, s0.out_group, e.due, e.stg, e.grp);
                    else
                        n_pass++;
                end
            end else if (q0.size() > 0 && q0[0].due == cyc) begin
                n_chk++;
                $display("FAIL out_missing cyc=%0d got out_valid=0 expected stage=%0d group=%0d", cyc, q0[0].stg, q0[0].grp);
                void'(q0.pop_front());
            end
        end
    end

    task automatic tick(input logic st, input logic fl, input logic iv);
        @(posedge clk);
        #1;
        s0.start    = st;
        s0.flush    = fl;
        s0.in_valid = iv;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int acc;
        n_chk++;
        if ({s0.in_ready, s0.out_valid, s0.busy, s0.done} !== 4'b0)
            $display("FAIL reset_ctrl got %b expected 0000", {s0.in_ready, s0.out_valid, s0.busy, s0.done});
        else n_pass++;
        n_chk++;
        if ({s0.out_stage, s0.out_group, s0.tf_stage, s0.tf_group} !== 12'h0)
            $display("FAIL reset_idx got %h expected 000", {s0.out_stage, s0.out_group, s0.tf_stage, s0.tf_group});
        else n_pass++;
        n_chk++;
        if ({s1.in_ready, s1.out_valid, s1.busy, s1.done} !== 4'b0)
            $display("FAIL reset_small got %b expected 0000", {s1.in_ready, s1.out_valid, s1.busy, s1.done});
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            n_chk++;
            if (s0.tf_req !== 1'b1 || s0.tf_group !== 4'(acc) || s0.tf_stage !== 2'd0)
                $display("FAIL prereset_accept got req=%b group=%0d expected req=1 group=%0d", s0.tf_req, s0.tf_group, acc);
            else n_pass++;
            q0.push_back('{due: cyc + 2, stg: 2'd0, grp: 4'(acc)});
            acc++;
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        s0.in_valid = 1'b0;
        #1;
        n_chk++;
        if ({s0.in_ready, s0.out_valid, s0.busy, s0.done} !== 4'b0)
            $display("FAIL midrun_reset_ctrl got %b expected 0000", {s0.in_ready, s0.out_valid, s0.busy, s0.done});
        else n_pass++;
        n_chk++;
        if ({s0.out_stage, s0.out_group, s0.tf_stage, s0.tf_group} !== 12'h0)
            $display("FAIL midrun_reset_idx got %h expected 000", {s0.out_stage, s0.out_group, s0.tf_stage, s0.tf_group});
        else n_pass++;
        q0.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (s0.busy !== 1'b0 || s0.done !== 1'b0)
            $display("FAIL postreset_idle got busy=%b done=%b expected 0 0", s0.busy, s0.done);
        else n_pass++;
    endtask

    // mode 0: continuous, 1: in_valid toggling, 2: start pulses during RUN and DRAIN
    task automatic test_stream(input int mode);
        int   acc = 0;
        int   last = 1 << 30;
        int   dones = 0;
        logic iv;
        logic st;
        tick(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (s0.in_ready !== 1'b0) $display("FAIL start_cycle_ready mode=%0d got %b expected 0", mode, s0.in_ready);
        else n_pass++;
        for (int k = 0; k < 300; k++) begin
            iv = (acc < 48) && (mode != 1 || (k % 2) == 0);
            st = (mode == 2) && (k == 10 || (cyc + 1 > last && cyc + 1 <= last + 2));
            tick(st, 1'b0, iv);
            n_chk++;
            if (s0.tf_req !== iv || s0.in_ready !== (cyc <= last))
                $display("FAIL tf_req mode=%0d cyc=%0d got req=%b ready=%b expected req=%b ready=%b",
                         mode, cyc, s0.tf_req, s0.in_ready, iv, (cyc <= last));
            else n_pass++;
            n_chk++;
            if (s0.busy !== (cyc <= last + 2) || s0.done !== (cyc == last + 3))
                $display("FAIL busy_done mode=%0d cyc=%0d got busy=%b done=%b expected busy=%b done=%b",
                         mode, cyc, s0.busy, s0.done, (cyc <= last + 2), (cyc == last + 3));
            else n_pass++;
            if (s0.done) dones++;
            if (iv) begin
                n_chk++;
                if (s0.tf_stage !== 2'(acc / 16) || s0.tf_group !== 4'(acc % 16))
                    $display("FAIL tf_index mode=%0d got stage=%0d group=%0d expected stage=%0d group=%0d",
                             mode, s0.tf_stage, s0.tf_group, acc / 16, acc % 16);
                else n_pass++;
                q0.push_back('{due: cyc + 2, stg: 2'(acc / 16), grp: 4'(acc % 16)});
                acc++;
                if (acc == 48) last = cyc;
            end
            if (cyc >= last + 4) break;
        end
        n_chk++;
        if (acc !== 48 || dones !== 1 || q0.size() !== 0)
            $display("FAIL stream_totals mode=%0d got accepts=%0d dones=%0d pending=%0d expected 48 1 0",
                     mode, acc, dones, q0.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            q0.push_back('{due: cyc + 2, stg: 2'(k / 16), grp: 4'(k % 16)});
        end
        tick(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (s0.tf_stage !== 2'd1 || s0.tf_group !== 4'd4)
            $display("FAIL flush_counters got stage=%0d group=%0d expected stage=1 group=4", s0.tf_stage, s0.tf_group);
        else n_pass++;
        @(posedge clk);
        #1;
        s0.flush = 1'b0;
        while (q0.size() > 0 && q0[q0.size()-1].due >= cyc) void'(q0.pop_back());
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick(1'b0, 1'b0, 1'b0);
            else @(negedge clk);
            n_chk++;
            if ({s0.in_ready, s0.out_valid, s0.busy, s0.done} !== 4'b0 || {s0.tf_stage, s0.tf_group} !== 6'h0)
                $display("FAIL after_flush k=%0d got ready/ov/busy/done=%b idx=%h expected 0000 00", k,
                         {s0.in_ready, s0.out_valid, s0.busy, s0.done}, {s0.tf_stage, s0.tf_group});
            else n_pass++;
        end
    endtask

    task automatic test_small();
        int   acc = 0;
        int   last = 1 << 30;
        int   dones = 0;
        logic iv;
        @(posedge clk);
        #1 s1.start = 1'b1;
        @(negedge clk);
        n_chk++;
        if (s1.in_ready !== 1'b0) $display("FAIL small_start_ready got %b expected 0", s1.in_ready);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            iv          = (acc < 2);
            s1.start    = 1'b0;
            s1.in_valid = iv;
            @(negedge clk);
            n_chk++;
            if (s1.tf_req !== iv) $display("FAIL small_tf_req cyc=%0d got %b expected %b", cyc, s1.tf_req, iv);
            else n_pass++;
            if (iv) begin
                n_chk++;
                if (s1.tf_group !== 1'(acc) || s1.tf_stage !== 1'b0)
                    $display("FAIL small_tf_index got stage=%0d group=%0d expected stage=0 group=%0d", s1.tf_stage, s1.tf_group, acc);
                else n_pass++;
                q1.push_back('{due: cyc + 1, stg: 2'd0, grp: 4'(acc)});
                acc++;
                if (acc == 2) last = cyc;
            end
            if (s1.out_valid) begin
                n_chk++;
                if (q1.size() == 0) begin
                    $display("FAIL small_out_unexpected cyc=%0d got out_valid=1 expected 0", cyc);
                end else begin
                    ent_t e;
                    e = q1.pop_front();
                    if (e.due !== cyc || e.grp[0] !== s1.out_group || s1.out_stage !== 1'b0)
                        $display("FAIL small_out cyc=%0d got group=%0d expected cyc=%0d group=%0d", cyc, s1.out_group, e.due, e.grp);
                    else n_pass++;
                end
            end else if (q1.size() > 0 && q1[0].due == cyc) begin
                n_chk++;
                $display("FAIL small_out_missing cyc=%0d got out_valid=0 expected group=%0d", cyc, q1[0].grp);
                void'(q1.pop_front());
            end
            n_chk++;
            if (s1.done !== (cyc == last + 2))
                $display("FAIL small_done cyc=%0d got %b expected %b", cyc, s1.done, (cyc == last + 2));
            else n_pass++;
            if (s1.done) dones++;
        end
        n_chk++;
        if (acc !== 2 || dones !== 1 || q1.size() !== 0)
            $display("FAIL small_totals got accepts=%0d dones=%0d pending=%0d expected 2 1 0", acc, dones, q1.size());
        else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        s0.start    = 1'b0;
        s0.flush    = 1'b0;
        s0.in_valid = 1'b0;
        s1.start    = 1'b0;
        s1.flush    = 1'b0;
        s1.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_stream(0);
        test_stream(1);
        test_flush();
        test_stream(2);
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
